// File: rtl/mii_tx_deframer_pkg.sv
// Shared types and constants for the MII TX nibble-to-byte deframer.
// Stats counters are present only when MII_TX_DEFRAMER_STATS_EN is defined.
package mii_tx_deframer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_LO,
    ST_HI,
    ST_DISC
  } state_e;

  localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0] SFD_NIBBLE      = 4'hD;
  localparam logic [3:0] PRE_CNT_MAX     = 4'hF;
  localparam int         CNT_W           = 16;

  function automatic logic [3:0] sat_inc4(
    input logic [3:0] v
  );
    return (v == PRE_CNT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/mii_tx_deframer_sat_counter.sv
// Saturating event counter for the deframer statistics.
// Only built when MII_TX_DEFRAMER_STATS_EN is defined.
`ifdef MII_TX_DEFRAMER_STATS_EN
module mii_tx_deframer_sat_counter
  import mii_tx_deframer_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/mii_tx_deframer.sv
// MII TX deframer: preamble/SFD check, low-first nibble pairing, sof/eof.
// Optional MII_TX_DEFRAMER_STATS_EN adds frame_cnt and bad_cnt outputs.
module mii_tx_deframer
  import mii_tx_deframer_pkg::*;
#(
  parameter int MIN_PREAMBLE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             enable,
  input  logic             err,
  input  logic [3:0]       data,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_err,
  output logic             pre_bad
`ifdef MII_TX_DEFRAMER_STATS_EN
  ,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] bad_cnt
`endif
);

  localparam logic [3:0] MIN_CNT = 4'(MIN_PREAMBLE);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] lo_q, lo_d;
  logic       lo_err_q, lo_err_d;
  logic [7:0] pend_q, pend_d;
  logic       pend_err_q, pend_err_d;
  logic       pend_sof_q, pend_sof_d;
  logic       pend_vld_q, pend_vld_d;
  logic       sof_q, sof_d;
  logic       arm_q;
  logic       vld_q, vld_d;
  logic [7:0] odat_q, odat_d;
  logic       osof_q, osof_d;
  logic       oeof_q, oeof_d;
  logic       oerr_q, oerr_d;
  logic       bad_q, bad_d;
  logic       ce_ok;

  // First edge after reset release is swallowed so a coincident ce is ignored.
  assign ce_ok = ce & arm_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    lo_err_d   = lo_err_q;
    pend_d     = pend_q;
    pend_err_d = pend_err_q;
    pend_sof_d = pend_sof_q;
    pend_vld_d = pend_vld_q;
    sof_d      = sof_q;
    vld_d      = 1'b0;
    odat_d     = odat_q;
    osof_d     = 1'b0;
    oeof_d     = 1'b0;
    oerr_d     = 1'b0;
    bad_d      = 1'b0;
    if (ce_ok) begin
      unique case (state_q)
        ST_IDLE: begin
          if (enable) begin
            if (data == PREAMBLE_NIBBLE) begin
              state_d = ST_PRE;
              cnt_d   = 4'd1;
            end else begin
              state_d = ST_DISC;
              bad_d   = 1'b1;
            end
          end
        end
        ST_PRE: begin
          if (!enable) begin
            state_d = ST_IDLE;
            bad_d   = 1'b1;
          end else if (err) begin
            state_d = ST_DISC;
            bad_d   = 1'b1;
          end else if (data == PREAMBLE_NIBBLE) begin
            cnt_d = sat_inc4(cnt_q);
          end else if (data == SFD_NIBBLE && cnt_q >= MIN_CNT) begin
            state_d    = ST_LO;
            sof_d      = 1'b1;
            pend_vld_d = 1'b0;
          end else begin
            state_d = ST_DISC;
            bad_d   = 1'b1;
          end
        end
        ST_LO: begin
          if (enable) begin
            lo_d     = data;
            lo_err_d = err;
            state_d  = ST_HI;
          end else begin
            state_d    = ST_IDLE;
            pend_vld_d = 1'b0;
            if (pend_vld_q) begin
              vld_d  = 1'b1;
              odat_d = pend_q;
              osof_d = pend_sof_q;
              oeof_d = 1'b1;
              oerr_d = pend_err_q;
            end else begin
              bad_d = 1'b1;
            end
          end
        end
        ST_HI: begin
          if (enable) begin
            if (pend_vld_q) begin
              vld_d  = 1'b1;
              odat_d = pend_q;
              osof_d = pend_sof_q;
              oerr_d = pend_err_q;
            end
            pend_d     = {data, lo_q};
            pend_err_d = lo_err_q | err;
            pend_sof_d = sof_q;
            pend_vld_d = 1'b1;
            sof_d      = 1'b0;
            state_d    = ST_LO;
          end else begin
            // Odd end: the half nibble is dropped and the last byte tainted.
            state_d    = ST_IDLE;
            pend_vld_d = 1'b0;
            if (pend_vld_q) begin
              vld_d  = 1'b1;
              odat_d = pend_q;
              osof_d = pend_sof_q;
              oeof_d = 1'b1;
              oerr_d = 1'b1;
            end else begin
              bad_d = 1'b1;
            end
          end
        end
        ST_DISC: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      lo_q       <= 4'd0;
      lo_err_q   <= 1'b0;
      pend_q     <= 8'd0;
      pend_err_q <= 1'b0;
      pend_sof_q <= 1'b0;
      pend_vld_q <= 1'b0;
      sof_q      <= 1'b0;
      arm_q      <= 1'b0;
      vld_q      <= 1'b0;
      odat_q     <= 8'd0;
      osof_q     <= 1'b0;
      oeof_q     <= 1'b0;
      oerr_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      lo_err_q   <= lo_err_d;
      pend_q     <= pend_d;
      pend_err_q <= pend_err_d;
      pend_sof_q <= pend_sof_d;
      pend_vld_q <= pend_vld_d;
      sof_q      <= sof_d;
      arm_q      <= 1'b1;
      vld_q      <= vld_d;
      odat_q     <= odat_d;
      osof_q     <= osof_d;
      oeof_q     <= oeof_d;
      oerr_q     <= oerr_d;
      bad_q      <= bad_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = odat_q;
  assign out_sof   = osof_q;
  assign out_eof   = oeof_q;
  assign out_err   = oerr_q;
  assign pre_bad   = bad_q;

`ifdef MII_TX_DEFRAMER_STATS_EN
  logic good_eof;
  logic bad_evt;

  assign good_eof = vld_q & oeof_q & ~oerr_q;
  assign bad_evt  = bad_q | (vld_q & oeof_q & oerr_q);

  mii_tx_deframer_sat_counter #(
    .W(CNT_W)
  ) u_frame_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(good_eof),
    .cnt_o(frame_cnt)
  );

  mii_tx_deframer_sat_counter #(
    .W(CNT_W)
  ) u_bad_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(bad_evt),
    .cnt_o(bad_cnt)
  );
`endif

endmodule
